// File: rtl/instr_fetch_if.sv
// instr_fetch_if -- bus bundle between the instruction fetch unit, the
// instruction memory and the decoder.
//
// Signals:
//   imem_req / imem_addr      fetch request and word-aligned address (fetch unit out)
//   imem_ack / imem_rdata     memory completion and returned word (fetch unit in)
//   instr / instr_pc          instruction word and its address (fetch unit out)
//   instr_valid / instr_ready decoder handshake
//   redirect / redirect_pc    taken-branch pulse and new fetch target (fetch unit in)
//   fetch_err                 sticky misaligned-redirect flag (fetch unit out)
//
// Modports:
//   master -- the fetch unit
//   slave  -- the environment (memory + decoder + branch unit)
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch -- single-outstanding-request instruction fetch unit.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    instr_fetch_if.master (memory request, decoder handshake, redirect)
//
// Parameter:
//   RESET_PC  address of the first fetch after reset
//
// Optional feature:
//   IFETCH_ALIGN_CHECK_EN  when defined, misaligned redirects are ignored and
//                          raise the sticky fetch_err flag; otherwise the low
//                          two bits of redirect_pc are cleared on load and
//                          fetch_err is tied low.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// REQ   | request at fetch pc outstanding
// HOLD  | instruction presented to decoder, waiting for instr_ready
// FLUSH | finishing a request made before a redirect; its data is dropped
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {BOOT, REQ, HOLD, FLUSH} state_t;

    state_t      state, stateNext;
    logic [31:0] fetchPc;
    logic [31:0] flushAddr;
    logic [31:0] instrReg;
    logic [31:0] instrPcReg;
    logic        instrValidReg;
    logic [31:0] redirTarget;
    logic        redirOk;
    logic        misaligned;

    logic        loadRedir;
    logic        saveFlush;
    logic        capture;
    logic        dropValid;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fetchErrReg;

    assign misaligned  = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
    assign redirOk     = bus.redirect && !misaligned;
    assign redirTarget = bus.redirect_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetchErrReg <= 1'b0;
        else if (misaligned)
            fetchErrReg <= 1'b1;
    end

    assign bus.fetch_err = fetchErrReg;
`else
    assign misaligned    = 1'b0;
    assign redirOk       = bus.redirect;
    assign redirTarget   = bus.redirect_pc & 32'hFFFF_FFFC;
    assign bus.fetch_err = misaligned;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= BOOT;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        loadRedir = 1'b0;
        saveFlush = 1'b0;
        capture   = 1'b0;
        dropValid = 1'b0;
        case (state)
            BOOT: begin
                loadRedir = redirOk;
                stateNext = REQ;
            end
            REQ: begin
                if (redirOk) begin
                    // A word returned alongside a redirect is stale; just
                    // re-aim the fetch pc and issue a fresh request.
                    loadRedir = 1'b1;
                    if (!bus.imem_ack) begin
                        saveFlush = 1'b1;
                        stateNext = FLUSH;
                    end
                end else if (bus.imem_ack) begin
                    capture   = 1'b1;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                // The handshake completes even when a redirect coincides.
                if (bus.instr_ready || redirOk) begin
                    dropValid = 1'b1;
                    loadRedir = redirOk;
                    stateNext = REQ;
                end
            end
            FLUSH: begin
                loadRedir = redirOk;
                if (bus.imem_ack)
                    stateNext = REQ;
            end
            default: stateNext = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc       <= RESET_PC;
            flushAddr     <= RESET_PC;
            instrReg      <= 32'h0;
            instrPcReg    <= 32'h0;
            instrValidReg <= 1'b0;
        end else begin
            if (loadRedir)
                fetchPc <= redirTarget;
            else if (capture)
                fetchPc <= fetchPc + 32'd4;

            // The request address must stay stable until the old ack.
            if (saveFlush)
                flushAddr <= fetchPc;

            if (capture) begin
                instrReg      <= bus.imem_rdata;
                instrPcReg    <= fetchPc;
                instrValidReg <= 1'b1;
            end else if (dropValid) begin
                instrValidReg <= 1'b0;
            end
        end
    end

    assign bus.imem_req    = (state == REQ) || (state == FLUSH);
    assign bus.imem_addr   = (state == FLUSH) ? flushAddr : fetchPc;
    assign bus.instr       = instrReg;
    assign bus.instr_pc    = instrPcReg;
    assign bus.instr_valid = instrValidReg;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch -- directed bench for instr_fetch.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, before the next edge.
module tb_instr_fetch;
    logic clk;
    logic reset;
    int   vecs;
    int   errs;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        step();
        step();
        vecs++;
        if ({bus.imem_req, bus.instr_valid, bus.fetch_err, bus.instr, bus.instr_pc} !== {3'b000, 64'h0}) begin
            errs++;
            $display("FAIL reset_state got req=%b v=%b err=%b instr=%h pc=%h exp all zero",
                     bus.imem_req, bus.instr_valid, bus.fetch_err, bus.instr, bus.instr_pc);
        end
        reset = 1'b0;
        vecs++;
        if (bus.imem_req !== 1'b0) begin
            errs++;
            $display("FAIL boot_no_req got=%b exp=0", bus.imem_req);
        end
        step();
        vecs++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errs++;
            $display("FAIL first_req got req=%b addr=%h v=%b exp req=1 addr=0 v=0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] expAddr;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expAddr = 32'(4 * (i / 2));
            if (i % 2 == 0) begin
                vecs++;
                if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, expAddr, 1'b0}) begin
                    errs++;
                    $display("FAIL zero_wait_req[%0d] got req=%b addr=%h v=%b exp req=1 addr=%h v=0",
                             i, bus.imem_req, bus.imem_addr, bus.instr_valid, expAddr);
                end
                bus.imem_ack = 1'b1;
                bus.imem_rdata = word(expAddr);
            end else begin
                vecs++;
                if ({bus.imem_req, bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b0, 1'b1, expAddr, word(expAddr)}) begin
                    errs++;
                    $display("FAIL zero_wait_valid[%0d] got req=%b v=%b pc=%h instr=%h exp req=0 v=1 pc=%h instr=%h",
                             i, bus.imem_req, bus.instr_valid, bus.instr_pc, bus.instr, expAddr, word(expAddr));
                end
                bus.imem_ack = 1'b0;
            end
            step();
        end
        vecs++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hC}) begin
            errs++;
            $display("FAIL zero_wait_next got req=%b addr=%h exp req=1 addr=0000000c", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_hold();
        bus.instr_ready = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = word(32'hC);
        step();
        // ack during HOLD must be ignored
        bus.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if ({bus.imem_req, bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b0, 1'b1, 32'hC, word(32'hC)}) begin
                errs++;
                $display("FAIL hold[%0d] got req=%b v=%b pc=%h instr=%h exp req=0 v=1 pc=0000000c instr=%h",
                         i, bus.imem_req, bus.instr_valid, bus.instr_pc, bus.instr, word(32'hC));
            end
            step();
        end
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b1;
        step();
        vecs++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h10, 1'b0}) begin
            errs++;
            $display("FAIL hold_release got req=%b addr=%h v=%b exp req=1 addr=00000010 v=0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
    endtask

    task automatic test_wait_ack();
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h10, 1'b0}) begin
                errs++;
                $display("FAIL wait_ack[%0d] got req=%b addr=%h v=%b exp req=1 addr=00000010 v=0",
                         i, bus.imem_req, bus.imem_addr, bus.instr_valid);
            end
            bus.imem_ack = (i == 3);
            bus.imem_rdata = 32'h1234_5678;
            step();
        end
        bus.imem_ack = 1'b0;
        vecs++;
        if ({bus.imem_req, bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b0, 1'b1, 32'h10, 32'h1234_5678}) begin
            errs++;
            $display("FAIL wait_ack_data got req=%b v=%b pc=%h instr=%h exp req=0 v=1 pc=00000010 instr=12345678",
                     bus.imem_req, bus.instr_valid, bus.instr_pc, bus.instr);
        end
        step();
    endtask

    task automatic test_redirect_ack();
        // REQ at 0x14: redirect coinciding with ack drops the word
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hBAD0_0014;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h20;
        step();
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        vecs++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h20, 1'b0}) begin
            errs++;
            $display("FAIL redirect_ack got req=%b addr=%h v=%b exp req=1 addr=00000020 v=0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
    endtask

    task automatic test_redirect_pending();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h400;
        step();
        bus.redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vecs++;
            if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h20, 1'b0}) begin
                errs++;
                $display("FAIL flush_old_addr[%0d] got req=%b addr=%h v=%b exp req=1 addr=00000020 v=0",
                         i, bus.imem_req, bus.imem_addr, bus.instr_valid);
            end
            if (i == 1) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = 32'hBAD0_0020;
            end
            step();
        end
        bus.imem_ack = 1'b0;
        vecs++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h400, 1'b0}) begin
            errs++;
            $display("FAIL flush_done got req=%b addr=%h v=%b exp req=1 addr=00000400 v=0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = word(32'h400);
        step();
        bus.imem_ack = 1'b0;
        vecs++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'h400, word(32'h400)}) begin
            errs++;
            $display("FAIL redirect_first_valid got v=%b pc=%h instr=%h exp v=1 pc=00000400 instr=%h",
                     bus.instr_valid, bus.instr_pc, bus.instr, word(32'h400));
        end
    endtask

    task automatic test_redirect_hold();
        // In HOLD with instr_ready=1 and a redirect on the same cycle
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h800;
        step();
        bus.redirect = 1'b0;
        vecs++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h800, 1'b0}) begin
            errs++;
            $display("FAIL redirect_hold_ready got req=%b addr=%h v=%b exp req=1 addr=00000800 v=0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        bus.instr_ready = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = word(32'h800);
        step();
        bus.imem_ack = 1'b0;
        vecs++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'h800, word(32'h800)}) begin
            errs++;
            $display("FAIL fetch_800 got v=%b pc=%h instr=%h exp v=1 pc=00000800 instr=%h",
                     bus.instr_valid, bus.instr_pc, bus.instr, word(32'h800));
        end
        // Redirect in HOLD while the decoder is stalled
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h900;
        step();
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b1;
        vecs++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h900, 1'b0}) begin
            errs++;
            $display("FAIL redirect_hold_stall got req=%b addr=%h v=%b exp req=1 addr=00000900 v=0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
    endtask

    task automatic test_flush_overwrite();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hA00;
        step();
        bus.redirect_pc = 32'hB00;
        step();
        bus.redirect = 1'b0;
        vecs++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h900, 1'b0}) begin
            errs++;
            $display("FAIL flush_redirect_old got req=%b addr=%h v=%b exp req=1 addr=00000900 v=0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hBAD0_0900;
        step();
        vecs++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'hB00, 1'b0}) begin
            errs++;
            $display("FAIL flush_overwrite got req=%b addr=%h v=%b exp req=1 addr=00000b00 v=0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        bus.imem_rdata = word(32'hB00);
        step();
        bus.imem_ack = 1'b0;
        vecs++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'hB00, word(32'hB00)}) begin
            errs++;
            $display("FAIL fetch_b00 got v=%b pc=%h instr=%h exp v=1 pc=00000b00 instr=%h",
                     bus.instr_valid, bus.instr_pc, bus.instr, word(32'hB00));
        end
        step();
    endtask

    task automatic test_misaligned();
        // REQ at 0xB04, request pending
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h402;
        step();
        bus.redirect = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        vecs++;
        if ({bus.fetch_err, bus.imem_req, bus.imem_addr, bus.instr_valid} !== {2'b11, 32'hB04, 1'b0}) begin
            errs++;
            $display("FAIL misaligned_ignored got err=%b req=%b addr=%h v=%b exp err=1 req=1 addr=00000b04 v=0",
                     bus.fetch_err, bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = word(32'hB04);
        step();
        bus.imem_ack = 1'b0;
        vecs++;
        if ({bus.fetch_err, bus.instr_valid, bus.instr_pc, bus.instr} !== {2'b11, 32'hB04, word(32'hB04)}) begin
            errs++;
            $display("FAIL misaligned_seq got err=%b v=%b pc=%h instr=%h exp err=1 v=1 pc=00000b04 instr=%h",
                     bus.fetch_err, bus.instr_valid, bus.instr_pc, bus.instr, word(32'hB04));
        end
        step();
`else
        vecs++;
        if ({bus.fetch_err, bus.imem_req, bus.imem_addr, bus.instr_valid} !== {2'b01, 32'hB04, 1'b0}) begin
            errs++;
            $display("FAIL misaligned_flush got err=%b req=%b addr=%h v=%b exp err=0 req=1 addr=00000b04 v=0",
                     bus.fetch_err, bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hBAD0_0B04;
        step();
        vecs++;
        if ({bus.fetch_err, bus.imem_req, bus.imem_addr} !== {2'b01, 32'h400}) begin
            errs++;
            $display("FAIL misaligned_forced got err=%b req=%b addr=%h exp err=0 req=1 addr=00000400",
                     bus.fetch_err, bus.imem_req, bus.imem_addr);
        end
        bus.imem_rdata = word(32'h400);
        step();
        bus.imem_ack = 1'b0;
        vecs++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'h400, word(32'h400)}) begin
            errs++;
            $display("FAIL misaligned_fetch got v=%b pc=%h instr=%h exp v=1 pc=00000400 instr=%h",
                     bus.instr_valid, bus.instr_pc, bus.instr, word(32'h400));
        end
        step();
`endif
    endtask

    task automatic test_wrap();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hBAD0_FFFF;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        vecs++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errs++;
            $display("FAIL wrap_target got req=%b addr=%h exp req=1 addr=fffffffc", bus.imem_req, bus.imem_addr);
        end
        bus.imem_rdata = word(32'hFFFF_FFFC);
        step();
        bus.imem_ack = 1'b0;
        step();
        vecs++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_pc} !== {1'b1, 32'h0, 32'hFFFF_FFFC}) begin
            errs++;
            $display("FAIL wrap_next got req=%b addr=%h pc=%h exp req=1 addr=00000000 pc=fffffffc",
                     bus.imem_req, bus.imem_addr, bus.instr_pc);
        end
    endtask

    task automatic test_reset_mid();
        // Capture one word so instr is non-zero, then reset during a pending request
        bus.imem_ack = 1'b1;
        bus.imem_rdata = word(32'h0);
        step();
        bus.imem_ack = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        vecs++;
        if ({bus.imem_req, bus.instr_valid, bus.fetch_err, bus.instr, bus.instr_pc} !== {3'b000, 64'h0}) begin
            errs++;
            $display("FAIL reset_async got req=%b v=%b err=%b instr=%h pc=%h exp all zero",
                     bus.imem_req, bus.instr_valid, bus.fetch_err, bus.instr, bus.instr_pc);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hBAD0_0004;
        step();
        bus.imem_ack = 1'b0;
        vecs++;
        if ({bus.imem_req, bus.instr_valid, bus.instr} !== {2'b00, 32'h0}) begin
            errs++;
            $display("FAIL reset_abandon got req=%b v=%b instr=%h exp req=0 v=0 instr=0",
                     bus.imem_req, bus.instr_valid, bus.instr);
        end
        reset = 1'b0;
        step();
        vecs++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errs++;
            $display("FAIL reset_restart got req=%b addr=%h v=%b exp req=1 addr=00000000 v=0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_zero_wait();
        test_hold();
        test_wait_ack();
        test_redirect_ack();
        test_redirect_pending();
        test_redirect_hold();
        test_flush_overwrite();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
